// File: rtl/ripple_carry_adder_pkg.sv
// rtl/ripple_carry_adder_pkg.sv - shared constants and reference model for the ripple-carry adder
//
// Purpose:
//   Holds the default and maximum operand widths used by ripple_carry_adder,
//   plus a behavioural reference function that returns the exact
//   (width+1)-bit result of a + b + cin for any supported width.
//
// Contents:
//   RCA_DEFAULT_WIDTH  default operand width
//   RCA_MAX_WIDTH      widest operand width the adder supports
//   rca_ref_sum()      reference {carry, sum} for the low 'width' bits of a and b
package ripple_carry_adder_pkg;

    localparam int RCA_DEFAULT_WIDTH = 4;
    localparam int RCA_MAX_WIDTH     = 32;

    // Returns {carry_out, sum} in the low width+1 bits; upper bits are zero.
    // Operand bits above 'width' are ignored so callers may pass wider values.
    function automatic logic [RCA_MAX_WIDTH:0] rca_ref_sum(
        input logic [RCA_MAX_WIDTH-1:0] op_a,
        input logic [RCA_MAX_WIDTH-1:0] op_b,
        input logic                     cin,
        input int                       width
    );
        logic [RCA_MAX_WIDTH:0]   res_mask;
        logic [RCA_MAX_WIDTH-1:0] op_mask;
        logic [RCA_MAX_WIDTH:0]   full;
        res_mask = {(RCA_MAX_WIDTH + 1){1'b1}} >> (RCA_MAX_WIDTH - width);
        op_mask  = res_mask[RCA_MAX_WIDTH:1];
        full     = {1'b0, op_a & op_mask}
                 + {1'b0, op_b & op_mask}
                 + {{RCA_MAX_WIDTH{1'b0}}, cin};
        return full & res_mask;
    endfunction

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// rtl/ripple_carry_adder_full_adder.sv - single-bit combinational full adder
//
// Purpose:
//   One stage of the ripple-carry chain. Purely combinational.
//
// Ports:
//   a, b  input   operand bits
//   cin   input   carry in from the previous stage
//   s     output  sum bit
//   cout  output  carry out to the next stage
module full_adder
    import ripple_carry_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_sum;

    // Propagate term shared by the sum and the carry equations.
    assign half_sum = a ^ b;
    assign s        = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - parameterised ripple-carry adder with registered result
//
// Purpose:
//   Adds two unsigned WIDTH-bit operands plus a carry-in through a chain of
//   full_adder stages and registers the sum and carry-out, giving one cycle
//   of latency with no combinational input-to-output path.
//
// Parameters:
//   WIDTH     operand/sum width, 1..RCA_MAX_WIDTH (default RCA_DEFAULT_WIDTH)
//
// Ports:
//   clk       input   rising-edge clock
//   rst_n     input   asynchronous active-low reset, clears all outputs
//   a, b      input   unsigned addends
//   carryin   input   carry into bit 0
//   sum       output  registered (a + b + carryin) mod 2^WIDTH
//   carryout  output  registered carry out of bit WIDTH-1
//   overflow  output  registered signed overflow, only when
//                     RIPPLE_CARRY_ADDER_OVERFLOW_EN is defined
//
// Build option:
//   RIPPLE_CARRY_ADDER_OVERFLOW_EN  adds the overflow port and its register.
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic [WIDTH-1:0] sum,
    output logic             carryout
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    // Reject unsupported widths while elaborating rather than building a
    // silently truncated adder.
    if (WIDTH < 1 || WIDTH > RCA_MAX_WIDTH) begin : g_width_check
        $fatal(1, "ripple_carry_adder: WIDTH=%0d outside 1..%0d", WIDTH, RCA_MAX_WIDTH);
    end

    // c[i] is the carry into bit i; c[WIDTH] is the final carry out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = carryin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carryout_d;
    logic             carryout_q;

    always_comb begin
        sum_d      = s;
        carryout_d = c[WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= '0;
            carryout_q <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            carryout_q <= carryout_d;
        end
    end

    assign sum      = sum_q;
    assign carryout = carryout_q;

`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
    logic overflow_d;
    logic overflow_q;

    // Signed overflow: the carry into the sign bit differs from the carry out
    // of it. For WIDTH=1, c[0] is carryin, which keeps the rule consistent.
    always_comb begin
        overflow_d = c[WIDTH] ^ c[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb/tb_ripple_carry_adder.sv - self-checking bench for ripple_carry_adder (WIDTH=4 and WIDTH=8)
module tb_ripple_carry_adder;
    import ripple_carry_adder_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       carryin;
    logic [3:0] sum;
    logic       carryout;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       carryin8;
    logic [7:0] sum8;
    logic       carryout8;
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
    logic       overflow;
    logic       overflow8;
`endif

    int n_checks;
    int n_fail;

    ripple_carry_adder #(.WIDTH(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .carryin  (carryin),
        .sum      (sum),
        .carryout (carryout)
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    ripple_carry_adder #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a8),
        .b        (b8),
        .carryin  (carryin8),
        .sum      (sum8),
        .carryout (carryout8)
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
        ,
        .overflow (overflow8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] exp_sum;
        logic       exp_co;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [4:0]             exp_prev;
        logic                   ov_prev;
        logic [RCA_MAX_WIDTH:0] ref_full;
        logic [8:0]             exp8_prev;
        logic                   ov8_prev;

        n_checks = 0;
        n_fail   = 0;
        exp_prev = '0;
        ov_prev  = 1'b0;
        exp8_prev = '0;
        ov8_prev = 1'b0;

        vecs[0] = '{"f_plus_1",      4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
        vecs[1] = '{"f_plus_f_c1",   4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
        vecs[2] = '{"zero_c1",       4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0};
        vecs[3] = '{"f_plus_0_c1",   4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
        vecs[4] = '{"zero_zero",     4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
        vecs[5] = '{"ov_7_plus_1",   4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
        vecs[6] = '{"ov_8_plus_f",   4'h8, 4'hF, 1'b0, 4'h7, 1'b1, 1'b1};
        vecs[7] = '{"no_ov_3_2",     4'h3, 4'h2, 1'b0, 4'h5, 1'b0, 1'b0};
        vecs[8] = '{"mix_9_6_c1",    4'h9, 4'h6, 1'b1, 4'h0, 1'b1, 1'b0};

        // Asynchronous reset with no clock edge involved.
        rst_n = 1'b1;
        a = 4'h0; b = 4'h0; carryin = 1'b0;
        a8 = 8'h0; b8 = 8'h0; carryin8 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_sum_co", {4'h0, carryout, sum}, 9'h0);
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
        check("reset_ov", {8'h0, overflow}, 9'h0);
`endif
        a = 4'hF; b = 4'hF; carryin = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_hold", {4'h0, carryout, sum}, 9'h0);
        rst_n = 1'b1;

        // Exhaustive sweep, one new vector per cycle, result checked a cycle later.
        for (int i = 0; i <= 512; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("sweep", {4'h0, carryout, sum}, {4'h0, exp_prev});
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
                check("sweep_ov", {8'h0, overflow}, {8'h0, ov_prev});
`endif
            end
            if (i < 512) begin
                {carryin, a, b} = 9'(i);
                exp_prev = {1'b0, a} + {1'b0, b} + {4'h0, carryin};
                ov_prev  = (a[3] == b[3]) && (exp_prev[3] != a[3]);
            end
        end

        // Directed corner vectors.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; carryin = vecs[i].cin;
            @(negedge clk);
            check(vecs[i].name, {4'h0, carryout, sum}, {4'h0, vecs[i].exp_co, vecs[i].exp_sum});
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
            check({vecs[i].name, "_ov"}, {8'h0, overflow}, {8'h0, vecs[i].exp_ov});
`endif
        end

        // Latency: output holds until the next rising edge.
        @(negedge clk);
        a = 4'h2; b = 4'h1; carryin = 1'b0;
        @(negedge clk);
        check("lat_first", {5'h0, sum}, 9'h3);
        a = 4'h5;
        #1;
        check("lat_hold", {5'h0, sum}, 9'h3);
        @(posedge clk);
        #1;
        check("lat_update", {5'h0, sum}, 9'h6);

        // Mid-operation reset between edges.
        @(negedge clk);
        a = 4'h5; b = 4'h5; carryin = 1'b0;
        @(negedge clk);
        check("pre_reset_a", {5'h0, sum}, 9'hA);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_sum_co", {4'h0, carryout, sum}, 9'h0);
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
        check("midreset_ov", {8'h0, overflow}, 9'h0);
`endif
        a = 4'h3; b = 4'h4;
        @(negedge clk);
        check("midreset_hold", {4'h0, carryout, sum}, 9'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_3_4", {4'h0, carryout, sum}, 9'h7);

        // WIDTH=8 random vectors against the package reference.
        for (int i = 0; i <= 10000; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("rand8", {carryout8, sum8}, exp8_prev);
`ifdef RIPPLE_CARRY_ADDER_OVERFLOW_EN
                check("rand8_ov", {8'h0, overflow8}, {8'h0, ov8_prev});
`endif
            end
            if (i < 10000) begin
                a8       = 8'($urandom_range(0, 255));
                b8       = 8'($urandom_range(0, 255));
                carryin8 = 1'($urandom_range(0, 1));
                ref_full  = rca_ref_sum({24'h0, a8}, {24'h0, b8}, carryin8, 8);
                exp8_prev = ref_full[8:0];
                ov8_prev  = (a8[7] == b8[7]) && (exp8_prev[7] != a8[7]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
